// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor: adds K bits per clock over N/K RUN cycles and
// publishes s/co/ovf together, with a one-cycle done pulse.
module chunk_adder #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         co,
    output logic         ovf
);
    localparam int unsigned Chunks = N / K;
    localparam int unsigned CntW = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(Chunks - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [N-1:0]    s_q, s_d;
    logic            carry_q, carry_d;
    logic            co_q, co_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] idx_q, idx_d;
    logic [K:0]      chunk_sum;
    logic [N-1:0]    chunk_bits;
    logic            accept;

    // Operands shift right each cycle, so the active chunk is always at [K-1:0].
    assign chunk_sum  = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
    assign chunk_bits = N'(chunk_sum[K-1:0]) << (N - K);

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign accept = start && !busy;

    assign s   = s_q;
    assign co  = co_q;
    assign ovf = ovf_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                a_d     = a_q >> K;
                b_d     = b_q >> K;
                acc_d   = (acc_q >> K) | chunk_bits;
                carry_d = chunk_sum[K];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = DONE;
                    s_d     = acc_d;
                    co_d    = chunk_sum[K];
                    // a^b^s at the MSB recovers the carry into bit N-1.
                    ovf_d   = a_q[K-1] ^ b_q[K-1] ^ chunk_sum[K-1] ^ chunk_sum[K];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = RUN;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = ci ^ sub;
            acc_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_chunk_adder.sv
// Scoreboard bench for chunk_adder: an N=8/K=2 instance with directed and random
// traffic, plus an N=2/K=1 instance swept over all add combinations.
module tb_chunk_adder;
    localparam int N = 8;
    localparam int K = 2;
    localparam int C = N / K;

    logic clk = 1'b0;
    logic rst_n, rst2_n;
    logic start, sub, ci;
    logic [N-1:0] a, b, s;
    logic busy, done, co, ovf;
    logic start2, ci2;
    logic [1:0] a2, b2, s2;
    logic busy2, done2, co2, ovf2;

    typedef struct {
        logic [N-1:0] s;
        logic         co;
        logic         ovf;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t q2[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int next_ok = 0;
    bit ex2_done = 0;
    logic [N-1:0] held_s = '0;
    logic held_co = 1'b0;
    logic held_ovf = 1'b0;

    chunk_adder #(.N(N), .K(K)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
    );

    chunk_adder #(.N(2), .K(1)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2), .sub(1'b0), .a(a2), .b(b2), .ci(ci2),
        .busy(busy2), .done(done2), .s(s2), .co(co2), .ovf(ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Plain integer arithmetic: unsigned for s/co, signed range test for ovf.
    function automatic exp_t model(input int w, input logic [N-1:0] av, input logic [N-1:0] bv,
                                   input logic civ, input logic subv, input int due);
        exp_t e;
        int lim = 1 << w;
        int ua = int'(av);
        int ub = int'(bv);
        int c = int'(civ);
        int sa = (ua >= lim / 2) ? ua - lim : ua;
        int sb = (ub >= lim / 2) ? ub - lim : ub;
        int r, rs;
        if (!subv) begin
            r    = ua + ub + c;
            rs   = sa + sb + c;
            e.co = (r >= lim);
        end else begin
            r    = ua - ub - c;
            rs   = sa - sb - c;
            e.co = (ua >= ub + c);
        end
        e.s   = N'(((r % lim) + lim) % lim);
        e.ovf = (rs < -(lim / 2)) || (rs >= lim / 2);
        e.due = due;
        return e;
    endfunction

    // Called at a negedge; waits until the DUT is free (DONE counts as free).
    task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic civ, input logic subv);
        int acc;
        while (cyc + 1 < next_ok) @(negedge clk);
        acc     = cyc + 1;
        next_ok = acc + C + 1;
        a = av; b = bv; ci = civ; sub = subv; start = 1'b1;
        q.push_back(model(N, av, bv, civ, subv, acc + C));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_rand();
        issue(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        logic exp_busy;
        if (rst_n) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = q.pop_front();
                    chk("s", s, e.s);
                    chk("co", co, e.co);
                    chk("ovf", ovf, e.ovf);
                    chk("latency", cyc, e.due);
                    held_s = e.s; held_co = e.co; held_ovf = e.ovf;
                end
                chk("busy_in_done", busy, 0);
            end else begin
                exp_busy = (q.size() > 0) && (cyc >= q[0].due - C) && (cyc < q[0].due);
                chk("busy", busy, exp_busy);
                chk("s_hold", s, held_s);
                chk("co_hold", co, held_co);
                chk("ovf_hold", ovf, held_ovf);
            end
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (rst2_n && done2) begin
            if (q2.size() == 0) begin
                chk("n2_spurious_done", done2, 0);
            end else begin
                e = q2.pop_front();
                chk("n2_sum", {co2, s2}, {e.co, e.s[1:0]});
                chk("n2_ovf", ovf2, e.ovf);
                chk("n2_latency", cyc, e.due);
            end
        end
    end

    // Exhaustive 2-bit add sweep, back-to-back (start asserted in every DONE cycle).
    initial begin : drv2
        start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0; rst2_n = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            a2 = v[1:0]; b2 = v[3:2]; ci2 = v[4]; start2 = 1'b1;
            q2.push_back(model(2, N'(v[1:0]), N'(v[3:2]), v[4], 1'b0, cyc + 1 + 2));
            @(negedge clk);
            start2 = 1'b0;
            repeat (2) @(negedge clk);
        end
        ex2_done = 1'b1;
    end

    initial begin : drv
        int n;
        start = 1'b0; sub = 1'b0; a = '0; b = '0; ci = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_co", co, 0);
        chk("rst_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        issue(8'h05, 8'h07, 1'b0, 1'b1);
        issue(8'h80, 8'h01, 1'b0, 1'b1);

        // Start during the second RUN cycle must be ignored.
        issue(8'h12, 8'h34, 1'b1, 1'b0);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; sub = 1'b1; ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Back-to-back pair.
        issue(8'h3C, 8'hC3, 1'b0, 1'b0);
        issue(8'h90, 8'h20, 1'b1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(0, 3);
            repeat (n) @(negedge clk);
            issue_rand();
        end

        // Abort mid-RUN: outputs clear asynchronously and no done follows.
        issue(8'h11, 8'h22, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_s", s, 0);
        chk("abort_co", co, 0);
        chk("abort_ovf", ovf, 0);
        q.delete();
        held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
        next_ok = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        issue(8'h7F, 8'h7F, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) issue_rand();

        for (int i = 0; i < 300 && (q.size() > 0 || q2.size() > 0 || !ex2_done); i++)
            @(negedge clk);
        chk("drain_timeout", q.size() + q2.size() + (ex2_done ? 0 : 1), 0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
